// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions: response codes, protection bit positions
// and the channel state machine encodings used by the RAM responder.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PROT_PRIV = 0;
  localparam int PROT_NSEC = 1;
  localparam int PROT_INST = 2;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi_lite_ram_bank.sv
// Word-organised RAM with one byte-enabled write port and one registered
// read port. A read and a write to the same word on the same edge return
// the old contents. Contents are never reset.
module ram_bank #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // Registered read and byte-lane write; non-blocking updates give read-before-write
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-lite responder in front of a byte-writable word RAM. Read and write
// channels run independently with one outstanding transaction each. Out of
// range addresses answer DECERR, misaligned ones SLVERR, and instruction
// writes can be refused with SLVERR.
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int          DEPTH            = 1024,
  parameter logic [31:0] BASE             = 32'h0000_0000,
  parameter bit          ALLOW_INST_WRITE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  // Range check first, then alignment; offset wraps so addresses below BASE land out of range
  function automatic logic [1:0] decode(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= SPAN)
      return RESP_DECERR;
    else if (addr[1:0] != 2'b00)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  w_state_t w_state;
  r_state_t r_state;

  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr_q;
  logic [2:0]  aw_prot_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic [31:0] aw_addr_eff;
  logic [2:0]  aw_prot_eff;
  logic [31:0] w_data_eff;
  logic [3:0]  w_strb_eff;
  logic [31:0] aw_off;
  logic [31:0] ar_off;
  logic        commit;
  logic [1:0]  w_resp_calc;
  logic [1:0]  r_resp_calc;
  logic        ram_we;
  logic        rd_ok_q;
  logic [31:0] ram_rd_data;
  logic        unused_bits;

  assign awready = reset && (w_state == W_IDLE) && !aw_held;
  assign wready  = reset && (w_state == W_IDLE) && !w_held;
  assign arready = reset && (r_state == R_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign aw_addr_eff = aw_held ? aw_addr_q : awaddress;
  assign aw_prot_eff = aw_held ? aw_prot_q : awprot;
  assign w_data_eff  = w_held  ? w_data_q  : wdata;
  assign w_strb_eff  = w_held  ? w_strb_q  : wstrb;

  assign aw_off = aw_addr_eff - BASE;
  assign ar_off = araddress - BASE;

  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // Decode errors outrank the instruction-write protection check
  always_comb begin
    w_resp_calc = decode(aw_addr_eff);
    if (w_resp_calc == RESP_OKAY && aw_prot_eff[PROT_INST] && !ALLOW_INST_WRITE) begin
      w_resp_calc = RESP_SLVERR;
    end
  end

  assign r_resp_calc = decode(araddress);
  assign ram_we      = reset && commit && (w_resp_calc == RESP_OKAY);

  // Write channel: latch AW and W independently, commit once both are present, then hold B
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            w_state <= W_RESP;
            bvalid  <= 1'b1;
            bresp   <= w_resp_calc;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= awaddress;
              aw_prot_q <= awprot;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= wdata;
              w_strb_q <= wstrb;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: accept AR, present data and status until the initiator takes them
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rd_ok_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rresp   <= r_resp_calc;
            rd_ok_q <= (r_resp_calc == RESP_OKAY);
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign rdata = rd_ok_q ? ram_rd_data : 32'h0;

  ram_bank #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_idx  (aw_off[IDX_W+1:2]),
    .wr_strb (w_strb_eff),
    .wr_data (w_data_eff),
    .rd_en   (ar_hs),
    .rd_idx  (ar_off[IDX_W+1:2]),
    .rd_data (ram_rd_data)
  );

  assign unused_bits = ^{arprot, aw_off[31:IDX_W+2], aw_off[1:0],
                         ar_off[31:IDX_W+2], ar_off[1:0],
                         aw_prot_eff[PROT_NSEC], aw_prot_eff[PROT_PRIV]};

endmodule
